// File: rtl/pin_arbiter_module_pkg.sv
// Shared definitions for the pin arbiter: state encoding, default sizing and
// counter-width helper.
package pin_arbiter_module_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StGap
  } arb_state_e;

  localparam int unsigned DefNReq          = 4;
  localparam int unsigned DefGapCycles     = 5_000_000;   // 100 ms at 50 MHz
  localparam int unsigned DefTimeoutCycles = 50_000_000;  // 1 s at 50 MHz

  // Counter only ever reaches max(gap, timeout) - 1 before it is cleared.
  function automatic int unsigned cnt_width(int unsigned gap, int unsigned tmo);
    int unsigned m;
    m = (gap > tmo) ? gap : tmo;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/rr_pick_module.sv
// Combinational round-robin picker: first requester found scanning from
// (last + 1) mod N_REQ upward, wrapping around.
module rr_pick_module #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IdW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IdW-1:0]   last,
  output logic             valid,
  output logic [IdW-1:0]   index
);

  // Scan candidates in rotated priority order; the first hit wins.
  always_comb begin
    valid = 1'b0;
    index = last;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      int unsigned cand;
      cand = (32'(last) + k) % N_REQ;
      if (!valid && req[cand[IdW-1:0]]) begin
        valid = 1'b1;
        index = cand[IdW-1:0];
      end
    end
  end

endmodule

// File: rtl/pin_arbiter_module.sv
// Shares one serial output pin among N_REQ symbol generators. Grants are
// round-robin, each grant ends on the owner's done pulse or a timeout, and an
// idle-high gap follows every grant.
module pin_arbiter_module
  import pin_arbiter_module_pkg::*;
#(
  parameter int unsigned N_REQ          = DefNReq,
  parameter int unsigned GAP_CYCLES     = DefGapCycles,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_sig,
  input  logic [N_REQ-1:0]         done_sig,
  input  logic [N_REQ-1:0]         pin_in,
  output logic [N_REQ-1:0]         start_sig,
  output logic                     pin_out,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy_sig,
  output logic                     timeout_sig
);

  localparam int unsigned IdW  = $clog2(N_REQ);
  localparam int unsigned CntW = cnt_width(GAP_CYCLES, TIMEOUT_CYCLES);

  // Last count value of each timed phase; GapLast is unused when GAP_CYCLES is 0.
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast = CntW'(GAP_CYCLES - 1);

  arb_state_e      state;
  logic [CntW-1:0] cnt;
  logic            pick_valid;
  logic [IdW-1:0]  pick_idx;
  logic [N_REQ-1:0] pick_onehot;

  rr_pick_module #(
    .N_REQ (N_REQ),
    .IdW   (IdW)
  ) u_rr_pick (
    .req   (req_sig),
    .last  (grant_id),
    .valid (pick_valid),
    .index (pick_idx)
  );

  // Decode the picked index to the one-hot start vector.
  always_comb begin
    pick_onehot = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pick_onehot[i] = (pick_idx == IdW'(i));
    end
  end

  assign busy_sig = (state != StIdle);

  // Arbitration FSM with registered start, pin, grant and timeout outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StIdle;
      cnt         <= '0;
      start_sig   <= '0;
      pin_out     <= 1'b1;
      grant_id    <= IdW'(N_REQ - 1);  // so requester 0 wins first
      timeout_sig <= 1'b0;
    end else begin
      timeout_sig <= 1'b0;
      // start_sig is non-zero exactly while in StGrant.
      pin_out     <= (state == StGrant) ? pin_in[grant_id] : 1'b1;
      unique case (state)
        StIdle: begin
          if (pick_valid) begin
            state     <= StGrant;
            grant_id  <= pick_idx;
            start_sig <= pick_onehot;
            cnt       <= '0;
          end
        end
        StGrant: begin
          // Done wins over a coincident timeout.
          if (done_sig[grant_id]) begin
            start_sig <= '0;
            cnt       <= '0;
            state     <= (GAP_CYCLES == 0) ? StIdle : StGap;
          end else if (cnt == TmoLast) begin
            start_sig   <= '0;
            cnt         <= '0;
            timeout_sig <= 1'b1;
            state       <= (GAP_CYCLES == 0) ? StIdle : StGap;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StGap: begin
          if (cnt == GapLast) begin
            cnt   <= '0;
            state <= StIdle;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= StIdle;
          start_sig <= '0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pin_arbiter_module.sv
// Scoreboard bench: two arbiters (gap 4 and gap 0, timeout 20) share the same
// stimulus; a per-instance reference model pushes expected outputs every edge
// and a negedge monitor pops and compares them.
module tb_pin_arbiter_module;

  localparam int Gap0 = 4;
  localparam int Gap1 = 0;
  localparam int Tmo  = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_sig, done_sig, pin_in;
  logic [3:0] start0, start1;
  logic       pin0, pin1, busy0, busy1, tmo0_sig, tmo1_sig;
  logic [1:0] gid0, gid1;

  always #5 clk = ~clk;

  pin_arbiter_module #(.N_REQ(4), .GAP_CYCLES(Gap0), .TIMEOUT_CYCLES(Tmo)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_sig(req_sig), .done_sig(done_sig), .pin_in(pin_in),
    .start_sig(start0), .pin_out(pin0), .grant_id(gid0), .busy_sig(busy0),
    .timeout_sig(tmo0_sig)
  );

  pin_arbiter_module #(.N_REQ(4), .GAP_CYCLES(Gap1), .TIMEOUT_CYCLES(Tmo)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_sig(req_sig), .done_sig(done_sig), .pin_in(pin_in),
    .start_sig(start1), .pin_out(pin1), .grant_id(gid1), .busy_sig(busy1),
    .timeout_sig(tmo1_sig)
  );

  // Abstract model: mode 0 idle, 1 granted, 2 gap; elapsed = cycles spent in mode.
  typedef struct {
    int   mode;
    int   gid;
    int   elapsed;
    logic pin;
    logic tmo;
  } mdl_t;

  typedef struct packed {
    logic [3:0] start;
    logic       pin;
    logic [1:0] gid;
    logic       busy;
    logic       tmo;
  } exp_t;

  mdl_t m0, m1;
  exp_t q0[$], q1[$];
  int   ord0[$], ord1[$], len0[$];
  int   tmo0_cnt;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.mode = 0; m.gid = 3; m.elapsed = 0; m.pin = 1'b1; m.tmo = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, logic [3:0] req, logic [3:0] done,
                                    logic [3:0] pin, int gap, int tmo_c);
    mdl_t n;
    int   pick;
    n     = m;
    n.tmo = 1'b0;
    n.pin = (m.mode == 1) ? pin[m.gid] : 1'b1;
    if (m.mode == 0) begin
      pick = -1;
      for (int k = 1; k <= 4; k++) begin
        if (pick < 0 && req[(m.gid + k) % 4]) pick = (m.gid + k) % 4;
      end
      if (pick >= 0) begin
        n.gid = pick; n.mode = 1; n.elapsed = 0;
      end
    end else if (m.mode == 1) begin
      n.elapsed = m.elapsed + 1;
      if (done[m.gid] || n.elapsed == tmo_c) begin
        n.tmo     = !done[m.gid];
        n.mode    = (gap > 0) ? 2 : 0;
        n.elapsed = 0;
      end
    end else begin
      n.elapsed = m.elapsed + 1;
      if (n.elapsed >= gap) begin
        n.mode = 0; n.elapsed = 0;
      end
    end
    return n;
  endfunction

  function automatic exp_t exp_of(mdl_t m);
    exp_t e;
    e.start = (m.mode == 1) ? 4'(1 << m.gid) : 4'b0;
    e.pin   = m.pin;
    e.gid   = 2'(m.gid);
    e.busy  = (m.mode != 0);
    e.tmo   = m.tmo;
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic cmp_out(string tag, exp_t e, logic [3:0] st, logic po, logic [1:0] gi,
                         logic bu, logic to);
    chk({tag, ".start"}, 32'(st), 32'(e.start));
    chk({tag, ".pin"}, 32'(po), 32'(e.pin));
    chk({tag, ".gid"}, 32'(gi), 32'(e.gid));
    chk({tag, ".busy"}, 32'(bu), 32'(e.busy));
    chk({tag, ".tmo"}, 32'(to), 32'(e.tmo));
  endtask

  task automatic chk_order(string tag, int got[$], int want[$]);
    chk({tag, ".count"}, 32'(got.size() >= want.size()), 32'd1);
    for (int i = 0; i < want.size(); i++) begin
      if (i < got.size()) chk($sformatf("%s.grant[%0d]", tag, i), got[i], want[i]);
    end
  endtask

  // Reference model: step on each edge, queue the expected registered outputs.
  initial begin
    m0 = mdl_reset();
    m1 = mdl_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m0 = mdl_reset(); m1 = mdl_reset();
        q0.delete(); q1.delete();
      end else begin
        m0 = mdl_step(m0, req_sig, done_sig, pin_in, Gap0, Tmo);
        m1 = mdl_step(m1, req_sig, done_sig, pin_in, Gap1, Tmo);
        q0.push_back(exp_of(m0));
        q1.push_back(exp_of(m1));
      end
    end
  end

  // Monitor: compare DUT outputs mid-cycle and log grant order/lengths.
  initial begin
    logic [3:0] prev0, prev1;
    int         run0;
    exp_t       e;
    prev0 = '0; prev1 = '0; run0 = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cmp_out("rst0", exp_of(mdl_reset()), start0, pin0, gid0, busy0, tmo0_sig);
        cmp_out("rst1", exp_of(mdl_reset()), start1, pin1, gid1, busy1, tmo1_sig);
        prev0 = '0; prev1 = '0; run0 = 0;
      end else begin
        if (q0.size() > 0) begin
          e = q0.pop_front();
          cmp_out("u0", e, start0, pin0, gid0, busy0, tmo0_sig);
        end
        if (q1.size() > 0) begin
          e = q1.pop_front();
          cmp_out("u1", e, start1, pin1, gid1, busy1, tmo1_sig);
        end
        if (start0 != 0 && prev0 == 0) begin ord0.push_back(int'(gid0)); run0 = 0; end
        if (start0 != 0) run0++;
        if (start0 == 0 && prev0 != 0) len0.push_back(run0);
        if (tmo0_sig) tmo0_cnt++;
        if (start1 != 0 && prev1 == 0) ord1.push_back(int'(gid1));
        prev0 = start0; prev1 = start1;
      end
    end
  end

  // Drive inputs just after negedge; done follows the chosen model's grant.
  task automatic run(int cycles, logic [3:0] req_v, int done_after, bit use1,
                     logic [3:0] noise);
    for (int c = 0; c < cycles; c++) begin
      mdl_t       m;
      logic [3:0] own;
      @(negedge clk); #1;
      m        = use1 ? m1 : m0;
      own      = 4'(1 << m.gid);
      req_sig  = req_v;
      pin_in   = 4'($urandom);
      done_sig = '0;
      if (m.mode == 1) begin
        if (m.elapsed == 3) done_sig = noise & ~own;
        if (done_after > 0 && m.elapsed == done_after - 1) done_sig = done_sig | own;
      end
    end
  endtask

  task automatic do_reset(string tag);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk({tag, ".async_start0"}, 32'(start0), 32'd0);
    chk({tag, ".async_pin0"}, 32'(pin0), 32'd1);
    chk({tag, ".async_start1"}, 32'(start1), 32'd0);
    chk({tag, ".async_pin1"}, 32'(pin1), 32'd1);
    ord0.delete(); ord1.delete(); len0.delete();
    tmo0_cnt = 0;
    req_sig = '0; done_sig = '0;
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int want[$];
    rst_n = 1'b0; req_sig = '0; done_sig = '0; pin_in = '0; tmo0_cnt = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Single requester: 1-cycle grant latency, pin follows, done after 10.
    run(15, 4'b0001, 10, 1'b0, 4'b0000);
    run(30, 4'b0000, 0, 1'b0, 4'b0000);
    want = '{0};
    chk_order("single.u0", ord0, want);
    if (len0.size() > 0) chk("single.len0", len0[0], 10);

    // All requesting: round-robin 0,1,2,3,0.
    do_reset("rr");
    run(72, 4'b1111, 10, 1'b0, 4'b0000);
    run(40, 4'b0000, 0, 1'b0, 4'b0000);
    want = '{0, 1, 2, 3, 0};
    chk_order("rr.u0", ord0, want);

    // Foreign done bits ignored while requester 2 holds the grant.
    do_reset("foreign");
    run(20, 4'b0100, 8, 1'b0, 4'b1011);
    run(30, 4'b0000, 0, 1'b0, 4'b0000);
    want = '{2};
    chk_order("foreign.u0", ord0, want);
    if (len0.size() > 0) chk("foreign.len0", len0[0], 8);

    // Timeout: no done, two grants each forced off after 20 cycles.
    do_reset("tmo");
    run(30, 4'b0010, 0, 1'b0, 4'b0000);
    run(40, 4'b0000, 0, 1'b0, 4'b0000);
    want = '{1, 1};
    chk_order("tmo.u0", ord0, want);
    chk("tmo.pulses", tmo0_cnt, 2);
    if (len0.size() > 0) chk("tmo.len0", len0[0], Tmo);

    // Reset mid-grant drops outputs at once; requester 0 wins afterwards.
    do_reset("pre");
    run(5, 4'b1000, 0, 1'b0, 4'b0000);
    chk("mid.granted", 32'(start0), 32'b1000);
    do_reset("mid");
    run(20, 4'b1111, 10, 1'b0, 4'b0000);
    run(40, 4'b0000, 0, 1'b0, 4'b0000);
    want = '{0};
    chk_order("mid.u0", ord0, want);

    // Zero gap: alternate 0,1 with a single idle cycle between grants.
    do_reset("gap0");
    run(24, 4'b0011, 3, 1'b1, 4'b0000);
    run(30, 4'b0000, 0, 1'b1, 4'b0000);
    want = '{0, 1, 0, 1};
    chk_order("gap0.u1", ord1, want);

    // Random traffic: level requests, sparse done bits, occasional timeouts.
    do_reset("rand");
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk); #1;
      if ($urandom_range(0, 9) == 0) req_sig = 4'($urandom);
      done_sig = 4'($urandom & $urandom & $urandom);
      pin_in   = 4'($urandom);
    end
    run(40, 4'b0000, 0, 1'b0, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
